// File: rtl/hpdl_uart_pkg.sv
// Shared constants, state encodings and baud divider helper for the HPDL1414 UART feed.
// HPDL_UPPERCASE_EN (see uart_char_feed) uses the lowercase bounds defined here.
package hpdl_uart_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h5F;
    localparam logic [7:0] LOWER_LO = 8'h61;
    localparam logic [7:0] LOWER_HI = 8'h7A;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        FD_IDLE,
        FD_DECODE,
        FD_CHAR,
        FD_BS,
        FD_CLEAR
    } feed_state_t;

    // Rounded clocks-per-bit.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM, byte strobe and
// frame-error pulse (both one cycle, registered at the stop-bit sample).
module uart_rx_8n1
    import hpdl_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 12000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    logic             sync1_q, sync2_q;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!sync2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_o      = shift_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_char_feed.sv
// UART receive front end for the HPDL1414 path: holding register, character mapping,
// cursor and clear sequencer. Define HPDL_UPPERCASE_EN to fold 'a'..'z' onto 'A'..'Z'.
module uart_char_feed
    import hpdl_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 12000000,
    parameter int unsigned BAUD    = 9600,
    parameter int unsigned NUM_POS = 16
) (
    input  logic       CLK_i,
    input  logic       RST_i,
    input  logic       UART_RX,
    output logic [6:0] CHAR_o,
    output logic [3:0] POS_o,
    output logic       VALID_o,
    input  logic       READY_i,
    output logic       FRAME_ERR_o,
    output logic       OVERRUN_o
);

    localparam logic [3:0] LAST_POS = 4'(NUM_POS - 1);
    localparam logic [6:0] SPACE7   = CH_SPACE[6:0];

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ferr;

    feed_state_t state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic [3:0]  cursor_q, cursor_d;
    logic        valid_q, valid_d;
    logic [6:0]  char_q, char_d;
    logic [3:0]  pos_q, pos_d;
    logic        ovr_q, ovr_d;

    logic [7:0]  ch;
    logic [3:0]  bs_pos;
    logic        accept;

    uart_rx_8n1 #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_rx (
        .clk_i      (CLK_i),
        .rst_i      (RST_i),
        .rx_i       (UART_RX),
        .data_o     (rx_data),
        .valid_o    (rx_valid),
        .frame_err_o(rx_ferr)
    );

    function automatic logic [3:0] next_pos(input logic [3:0] p);
        return (p == LAST_POS) ? 4'd0 : p + 4'd1;
    endfunction

`ifdef HPDL_UPPERCASE_EN
    assign ch = (hold_q >= LOWER_LO && hold_q <= LOWER_HI) ? hold_q - 8'h20 : hold_q;
`else
    assign ch = hold_q;
`endif

    assign bs_pos = (cursor_q == 4'd0) ? 4'd0 : cursor_q - 4'd1;
    assign accept = valid_q && READY_i;

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q  <= FD_IDLE;
            hold_q   <= '0;
            cursor_q <= '0;
            valid_q  <= 1'b0;
            char_q   <= '0;
            pos_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cursor_q <= cursor_d;
            valid_q  <= valid_d;
            char_q   <= char_d;
            pos_q    <= pos_d;
            ovr_q    <= ovr_d;
        end
    end

    // Any state other than FD_IDLE means the holding register is busy, including the
    // cycle of the final accept, so a byte landing then is an overrun.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        cursor_d = cursor_q;
        valid_d  = valid_q;
        char_d   = char_q;
        pos_d    = pos_q;
        ovr_d    = rx_valid && (state_q != FD_IDLE);
        case (state_q)
            FD_IDLE: begin
                if (rx_valid) begin
                    hold_d  = rx_data;
                    state_d = FD_DECODE;
                end
            end
            FD_DECODE: begin
                state_d = FD_IDLE;
                if (ch >= PRINT_LO && ch <= PRINT_HI) begin
                    valid_d = 1'b1;
                    char_d  = ch[6:0];
                    pos_d   = cursor_q;
                    state_d = FD_CHAR;
                end else if (ch == CH_CR) begin
                    cursor_d = '0;
                end else if (ch == CH_BS) begin
                    cursor_d = bs_pos;
                    valid_d  = 1'b1;
                    char_d   = SPACE7;
                    pos_d    = bs_pos;
                    state_d  = FD_BS;
                end else if (ch == CH_FF) begin
                    valid_d = 1'b1;
                    char_d  = SPACE7;
                    pos_d   = '0;
                    state_d = FD_CLEAR;
                end
            end
            FD_CHAR: begin
                if (accept) begin
                    valid_d  = 1'b0;
                    cursor_d = next_pos(cursor_q);
                    state_d  = FD_IDLE;
                end
            end
            FD_BS: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = FD_IDLE;
                end
            end
            FD_CLEAR: begin
                if (accept) begin
                    if (pos_q == LAST_POS) begin
                        valid_d  = 1'b0;
                        cursor_d = '0;
                        state_d  = FD_IDLE;
                    end else begin
                        pos_d = pos_q + 4'd1;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = FD_IDLE;
            end
        endcase
    end

    assign CHAR_o      = char_q;
    assign POS_o       = pos_q;
    assign VALID_o     = valid_q;
    assign OVERRUN_o   = ovr_q;
    assign FRAME_ERR_o = rx_ferr;

endmodule

// File: tb/tb_uart_char_feed.sv
// Scoreboard bench for uart_char_feed at a scaled-down bit rate (16 clocks per bit).
// Expectations depend on HPDL_UPPERCASE_EN exactly as the DUT build does.
module tb_uart_char_feed;

    localparam int unsigned CLK_HZ  = 160;
    localparam int unsigned BAUD    = 10;
    localparam int unsigned NUM_POS = 16;
    localparam int DIV  = 16;   // (160 + 5) / 10
    localparam int HALF = 8;
    // start driven -> sync (2) -> START (HALF) -> 9 bits -> strobe -> hold -> VALID
    localparam int LATENCY = 5 + HALF + 9 * DIV;

    logic       CLK = 1'b0;
    logic       RST_i;
    logic       UART_RX;
    logic       READY_i;
    logic [6:0] CHAR_o;
    logic [3:0] POS_o;
    logic       VALID_o;
    logic       FRAME_ERR_o;
    logic       OVERRUN_o;

    always #5 CLK = ~CLK;

    uart_char_feed #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .NUM_POS(NUM_POS)
    ) dut (
        .CLK_i      (CLK),
        .RST_i      (RST_i),
        .UART_RX    (UART_RX),
        .CHAR_o     (CHAR_o),
        .POS_o      (POS_o),
        .VALID_o    (VALID_o),
        .READY_i    (READY_i),
        .FRAME_ERR_o(FRAME_ERR_o),
        .OVERRUN_o  (OVERRUN_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: stalled
    int model_cur  = 0;
    int last_start_cyc = 0;
    int last_rise_cyc  = 0;
    logic [10:0] exp_q[$];
    logic [10:0] e;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference behaviour for one received byte.
    task automatic expect_byte(input logic [7:0] b_in);
        logic [7:0] b;
        b = b_in;
`ifdef HPDL_UPPERCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) b = b - 8'h20;
`endif
        if (b >= 8'h20 && b <= 8'h5F) begin
            exp_q.push_back({b[6:0], 4'(model_cur)});
            model_cur = (model_cur == NUM_POS - 1) ? 0 : model_cur + 1;
        end else if (b == 8'h0D) begin
            model_cur = 0;
        end else if (b == 8'h08) begin
            model_cur = (model_cur == 0) ? 0 : model_cur - 1;
            exp_q.push_back({7'h20, 4'(model_cur)});
        end else if (b == 8'h0C) begin
            for (int p = 0; p < NUM_POS; p++) exp_q.push_back({7'h20, 4'(p)});
            model_cur = 0;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        @(posedge CLK); #1;
        UART_RX = 1'b0;
        last_start_cyc = cyc;
        repeat (DIV) @(posedge CLK);
        #1;
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (DIV) @(posedge CLK);
            #1;
        end
        UART_RX = stop_bit;
        repeat (DIV) @(posedge CLK);
        #1;
        UART_RX = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] b);
        expect_byte(b);
        send(b, 1'b1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || VALID_o) && k < 500) begin
            @(posedge CLK);
            k++;
        end
        #1;
        n_checks++;
        if (k >= 500) begin
            n_fail++;
            $display("FAIL %s: %0d requests still pending, expected 0", name, exp_q.size());
        end
        repeat (4) @(posedge CLK);
    endtask

    // READY_i driver
    initial begin
        READY_i = 1'b1;
        forever begin
            @(posedge CLK); #1;
            case (ready_mode)
                0:       READY_i = 1'b1;
                1:       READY_i = ~READY_i;
                default: READY_i = 1'b0;
            endcase
        end
    end

    // Monitor: counts pulses, checks stall stability, pops scoreboard on accept.
    initial begin
        logic prev_stall, prev_v;
        logic [6:0] prev_ch;
        logic [3:0] prev_pos;
        prev_stall = 1'b0;
        prev_v = 1'b0;
        prev_ch = '0;
        prev_pos = '0;
        forever begin
            @(negedge CLK);
            if (FRAME_ERR_o) fe_cnt++;
            if (OVERRUN_o) ov_cnt++;
            if (VALID_o && !prev_v) last_rise_cyc = cyc;
            prev_v = VALID_o;
            if (RST_i) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {VALID_o, CHAR_o, POS_o}, {1'b1, prev_ch, prev_pos});
                if (VALID_o && READY_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: got char 0x%0h pos %0d, expected no request",
                                 CHAR_o, POS_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("req", {CHAR_o, POS_o}, e);
                    end
                end
                prev_stall = VALID_o && !READY_i;
                prev_ch = CHAR_o;
                prev_pos = POS_o;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, o0, p0;
        RST_i = 1'b1;
        UART_RX = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid", VALID_o, 0);
        check("rst_char", CHAR_o, 0);
        check("rst_pos", POS_o, 0);
        check("rst_ferr", FRAME_ERR_o, 0);
        check("rst_ovr", OVERRUN_o, 0);
        RST_i = 1'b0;
        repeat (4) @(posedge CLK);

        // Basic requests and VALID latency
        send_ok(8'h41);
        check("valid_latency", last_rise_cyc - last_start_cyc, LATENCY);
        send_ok(8'h42);
        drain("basic");

        // 17 printable bytes from column 0: the 17th lands at POS 0
        send_ok(8'h0D);
        for (int i = 0; i < 17; i++) send_ok(8'(8'h30 + i));
        drain("wrap");

        // Form feed with READY toggling, then a character at POS 0
        ready_mode = 1;
        send_ok(8'h0C);
        drain("ff_clear");
        ready_mode = 0;
        send_ok(8'h58);
        drain("after_ff");

        // Frame error and start-bit glitch
        f0 = fe_cnt;
        send(8'h55, 1'b0);
        repeat (2 * DIV) @(posedge CLK);
        check("frame_err_pulse", fe_cnt - f0, 1);
        @(posedge CLK); #1;
        UART_RX = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        UART_RX = 1'b1;
        repeat (2 * DIV) @(posedge CLK);
        check("glitch_no_err", fe_cnt - f0, 1);
        drain("err_glitch");

        // Overrun while stalled
        ready_mode = 2;
        o0 = ov_cnt;
        p0 = model_cur;
        send_ok(8'h41);
        send(8'h42, 1'b1);
        repeat (4) @(posedge CLK);
        #1;
        check("overrun_pulse", ov_cnt - o0, 1);
        check("overrun_held", {VALID_o, CHAR_o, POS_o}, {1'b1, 7'h41, 4'(p0)});
        ready_mode = 0;
        drain("overrun");

        // Backspace at column 0 and at column 2
        send_ok(8'h0D);
        send_ok(8'h08);
        send_ok(8'h45);
        send_ok(8'h46);
        send_ok(8'h08);
        drain("backspace");

        // Lowercase, an ignored control byte, then a printable
        send_ok(8'h61);
        send_ok(8'h07);
        send_ok(8'h43);
        drain("lowercase");

        // Reset in the middle of a clear abandons it
        ready_mode = 2;
        send(8'h0C, 1'b1);
        repeat (4) @(posedge CLK);
        #1;
        check("ff_pending", VALID_o, 1);
        @(posedge CLK); #1;
        RST_i = 1'b1;
        @(posedge CLK); #1;
        check("midclr_valid", VALID_o, 0);
        check("midclr_pos", POS_o, 0);
        check("midclr_char", CHAR_o, 0);
        RST_i = 1'b0;
        exp_q.delete();
        model_cur = 0;
        ready_mode = 0;
        repeat (4) @(posedge CLK);
        send_ok(8'h5A);
        drain("after_reset");

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_char_feed.md
# uart_char_feed

UART receive front end for the HPDL1414 display path. It deserialises 8N1 bytes from the host serial line and interprets control characters. It then issues one (character, position) write request per displayed glyph over a valid/ready handshake to the HPDL1414 write-cycle driver, which sits directly downstream. It owns the cursor for the 16-character display (4 chips × 4 digits).

## Interface
- CLK_HZ, 12000000, system clock frequency in Hz
- BAUD, 9600, serial bit rate
- NUM_POS, 16, display positions (1..16); cursor wraps at NUM_POS-1
- CLK_i  in  1  system clock; single clock domain
- RST_i  in  1  reset; synchronous, active-high
- UART_RX  in  1  asynchronous serial input; idle high
- CHAR_o  out  7  character code for the display (0x20..0x5F)
- POS_o  out  4  target position, 0 = leftmost
- VALID_o  out  1  write request valid
- READY_i  in  1  downstream accepts request when VALID_o && READY_i
- FRAME_ERR_o  out  1  one-cycle pulse: stop bit sampled low
- OVERRUN_o  out  1  one-cycle pulse: byte dropped because the holding register was busy

## Operation
- UART_RX passes through a 2-FF synchroniser; both flops reset to 1.
- DIV = (CLK_HZ + BAUD/2) / BAUD (1250 at defaults); HALF = DIV/2.
- RX FSM states:
  - IDLE: leave on synchronised low.
  - START: wait HALF cycles, resample. Low → DATA; high → IDLE (glitch reject, no error).
  - DATA: 8 samples every DIV cycles, LSB first.
  - STOP: sample after DIV cycles. High → byte delivered. Low → FRAME_ERR_o pulse, byte discarded. Either way → IDLE.
- Holding register: one byte plus a busy flag. A delivered byte loads the register if it is free. If busy, the byte is dropped, OVERRUN_o pulses, and the held byte is unaffected.
- Byte interpretation (cursor reset 0):
  - 0x20..0x5F: request (byte, cursor); on accept, cursor = (cursor == NUM_POS-1) ? 0 : cursor+1.
  - 0x0D CR: cursor = 0; no request.
  - 0x08 BS: cursor = max(cursor-1, 0); then request (0x20, new cursor); cursor unchanged on accept.
  - 0x0C FF: NUM_POS requests (0x20, 0..NUM_POS-1) in order; cursor = 0 after the last accept.
  - Any other byte: dropped silently; busy cleared next cycle.
- Busy clears on the accept of the last request for the byte, or on the cycle it is dropped or cursor-only.
- Handshake:
  - CHAR_o and POS_o are stable while VALID_o is high and not accepted.
  - VALID_o never drops without an accept.
  - VALID_o may stay high across back-to-back FF requests.

## Timing
- Reset values: VALID_o=0, CHAR_o=0, POS_o=0, FRAME_ERR_o=0, OVERRUN_o=0; FSM IDLE; cursor 0; busy 0.
- Reset mid-frame or mid-clear: everything returns to reset values on the next edge, and the partial sequence is abandoned.
- Stop sample at cycle T → holding register loaded at edge T+1 → VALID_o high from T+2 for printable, BS, or FF bytes.
- During FF, with READY_i held high, one request is accepted per cycle, so NUM_POS cycles in total.
- Simultaneous events: an accept and a new byte delivery in the same cycle, where the accept is the final one, still count as busy; the new byte overruns.
- Minimum frame-to-frame gap: none. IDLE is re-entered at the mid-stop sample.

## Configuration
- HPDL_UPPERCASE_EN defined: bytes 0x61..0x7A are converted by subtracting 0x20 and treated as printable.
- HPDL_UPPERCASE_EN not defined: bytes 0x61..0x7A are "other" and dropped.

## Structure
- Package hpdl_uart_pkg holds:
  - control-code constants (CR, BS, FF, SPACE);
  - printable range bounds;
  - the RX state enum;
  - a function computing DIV from CLK_HZ and BAUD.
- Sub-module uart_rx_8n1 contains the synchroniser, the RX FSM and the baud counter. Its outputs are a byte, a one-cycle byte-valid strobe and a frame-error pulse.
- The top level holds the holding register, the character mapping, the cursor and the FF sequencer.

## Test plan
- Reset, send 0x41 then 0x42 with READY_i=1 → (0x41, POS 0) then (0x42, POS 1); VALID_o rises at T+2.
- Send 17 printable bytes → the 17th is requested at POS 0.
- Send 0x0C with READY_i toggling 1/0 → 16 requests of 0x20 at POS 0..15, stable while stalled. A following 0x58 goes to POS 0.
- Frame with low stop bit → FRAME_ERR_o high exactly 1 cycle, no VALID_o. A 0.3-bit start glitch → no error, no request.
- Hold READY_i=0 and send 0x41 then 0x42 → OVERRUN_o 1-cycle pulse; (0x41, 0) still presented; 0x42 never requested.
- Send 0x08 at cursor 0 → (0x20, POS 0). Send 0x61 → (0x41, cursor) with HPDL_UPPERCASE_EN; no request and cursor unchanged without it.
